// File: rtl/calcetin_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calcetin_pkg
// Description : Shared definitions for the sock packer: sock code names,
//               packer state encoding and code-width constants.
// Revision    : 1.0 - initial release
// ============================================================================
package calcetin_pkg;

  localparam int SOCK_CODE_W = 3;
  localparam int NUM_CODES   = 7;
  localparam int PAIR_CNT_W  = 8;

  // Sock codes; 0 marks an invalid / empty slot.
  localparam logic [SOCK_CODE_W-1:0] CODE_NONE   = 3'd0;
  localparam logic [SOCK_CODE_W-1:0] CODE_BLANCO = 3'd1;
  localparam logic [SOCK_CODE_W-1:0] CODE_NEGRO  = 3'd2;
  localparam logic [SOCK_CODE_W-1:0] CODE_GRIS   = 3'd3;
  localparam logic [SOCK_CODE_W-1:0] CODE_AZUL   = 3'd4;
  localparam logic [SOCK_CODE_W-1:0] CODE_ROJO   = 3'd5;
  localparam logic [SOCK_CODE_W-1:0] CODE_VERDE  = 3'd6;
  localparam logic [SOCK_CODE_W-1:0] CODE_RAYAS  = 3'd7;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_SEAL  = 2'd2
  } state_e;

  function automatic logic is_valid_code(input logic [SOCK_CODE_W-1:0] code);
    return code != CODE_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/empacadora_calcetines_seal_timer.sv
`default_nettype none
// ============================================================================
// Module      : seal_timer
// Description : Down-counter that times the box sealer. A start pulse loads
//               SEAL_CYCLES-1; 'last' is high during the final busy cycle.
// Ports       : clk, reset (async, active-high), start (in),
//               last (out, final cycle of the seal window)
// Revision    : 1.0 - initial release
// ============================================================================
module seal_timer #(
  parameter int SEAL_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic last
);

  localparam int CW = 8;

  logic [CW-1:0] count_q, count_d;
  logic          busy_q, busy_d;

  always_comb begin
    count_d = count_q;
    busy_d  = busy_q;
    if (start) begin
      count_d = CW'(SEAL_CYCLES - 1);
      busy_d  = 1'b1;
    end else if (busy_q) begin
      if (count_q == '0) begin
        busy_d = 1'b0;
      end else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end

  assign last = busy_q && (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/empacadora_calcetines.sv
`default_nettype none
// ============================================================================
// Module      : empacadora_calcetines
// Description : Sock packer. Pairs two consecutive socks of the same code,
//               counts pairs per code and seals a box every PAIRS_PER_BOX
//               pairs, backpressuring the knitter while the sealer runs.
// Ports       : clk, reset (async, active-high)
//               sock_valid, sock_code[2:0]   - sock offer (in)
//               ready                        - combinational accept enable
//               held, held_code[2:0]         - unpaired sock register
//               pair_out, reject, box_done   - one-cycle event pulses
//               box_code[2:0]                - code of the sealed box
//               total_boxes[CNT_W-1:0]       - boxes sealed, wrapping
// Revision    : 1.0 - initial release
// ============================================================================
module empacadora_calcetines
  import calcetin_pkg::*;
#(
  parameter int PAIRS_PER_BOX = 6,
  parameter int SEAL_CYCLES   = 4,
  parameter int CNT_W         = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sock_valid,
  input  logic [SOCK_CODE_W-1:0] sock_code,
  output logic                   ready,
  output logic                   held,
  output logic [SOCK_CODE_W-1:0] held_code,
  output logic                   pair_out,
  output logic                   reject,
  output logic                   box_done,
  output logic [SOCK_CODE_W-1:0] box_code,
  output logic [CNT_W-1:0]       total_boxes
);

  localparam logic [PAIR_CNT_W-1:0] PAIRS_TARGET = PAIR_CNT_W'(PAIRS_PER_BOX);

  state_e                 state_q, state_d;
  logic                   held_q, held_d;
  logic [SOCK_CODE_W-1:0] held_code_q, held_code_d;
  logic [SOCK_CODE_W-1:0] seal_code_q, seal_code_d;
  logic                   pair_out_q, pair_out_d;
  logic                   reject_q, reject_d;
  logic                   box_done_q, box_done_d;
  logic [SOCK_CODE_W-1:0] box_code_q, box_code_d;
  logic [CNT_W-1:0]       total_q, total_d;

  logic                   accept;
  logic                   pair_formed;
  logic                   seal_start;
  logic                   seal_last;
  // Bit i: counter for code i would reach a full box on its next pair.
  // Bit 0 is a constant 0 so the vector can be indexed by any sock code.
  logic [NUM_CODES:0]     cnt_full;

  assign ready  = (state_q != ST_SEAL);
  assign accept = sock_valid && ready;

  // held_code is nonzero whenever in HALF, so equality implies a valid code.
  assign pair_formed = accept && (state_q == ST_HALF) && (sock_code == held_code_q);
  assign seal_start  = pair_formed && cnt_full[sock_code];

  assign cnt_full[0] = 1'b0;

  // --------------------------------------------------------------------------
  // Pair counter bank, one counter per valid code.
  // --------------------------------------------------------------------------
  for (genvar i = 1; i <= NUM_CODES; i++) begin : g_pair_cnt
    logic [PAIR_CNT_W-1:0] cnt_q, cnt_d;
    logic                  hit;

    assign hit         = pair_formed && (sock_code == SOCK_CODE_W'(i));
    assign cnt_full[i] = ((cnt_q + 1'b1) == PAIRS_TARGET);

    always_comb begin
      cnt_d = cnt_q;
      if (hit) begin
        cnt_d = cnt_full[i] ? '0 : cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  seal_timer #(
    .SEAL_CYCLES (SEAL_CYCLES)
  ) u_seal_timer (
    .clk   (clk),
    .reset (reset),
    .start (seal_start),
    .last  (seal_last)
  );

  // --------------------------------------------------------------------------
  // FSM next state and registered outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    held_d      = held_q;
    held_code_d = held_code_q;
    seal_code_d = seal_code_q;
    total_d     = total_q;
    pair_out_d  = 1'b0;
    reject_d    = 1'b0;
    box_done_d  = 1'b0;
    box_code_d  = CODE_NONE;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          if (!is_valid_code(sock_code)) begin
            reject_d = 1'b1;
          end else begin
            state_d     = ST_HALF;
            held_d      = 1'b1;
            held_code_d = sock_code;
          end
        end
      end

      ST_HALF: begin
        if (accept) begin
          if (pair_formed) begin
            pair_out_d  = 1'b1;
            held_d      = 1'b0;
            held_code_d = CODE_NONE;
            if (seal_start) begin
              state_d     = ST_SEAL;
              seal_code_d = sock_code;
            end else begin
              state_d = ST_EMPTY;
            end
          end else begin
            // Either code 0 or a different code: the held sock is kept.
            reject_d = 1'b1;
          end
        end
      end

      ST_SEAL: begin
        if (seal_last) begin
          state_d    = ST_EMPTY;
          box_done_d = 1'b1;
          box_code_d = seal_code_q;
          total_d    = total_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      held_q      <= 1'b0;
      held_code_q <= CODE_NONE;
      seal_code_q <= CODE_NONE;
      pair_out_q  <= 1'b0;
      reject_q    <= 1'b0;
      box_done_q  <= 1'b0;
      box_code_q  <= CODE_NONE;
      total_q     <= '0;
    end else begin
      state_q     <= state_d;
      held_q      <= held_d;
      held_code_q <= held_code_d;
      seal_code_q <= seal_code_d;
      pair_out_q  <= pair_out_d;
      reject_q    <= reject_d;
      box_done_q  <= box_done_d;
      box_code_q  <= box_code_d;
      total_q     <= total_d;
    end
  end

  assign held        = held_q;
  assign held_code   = held_code_q;
  assign pair_out    = pair_out_q;
  assign reject      = reject_q;
  assign box_done    = box_done_q;
  assign box_code    = box_code_q;
  assign total_boxes = total_q;

endmodule
`default_nettype wire

// File: tb/tb_empacadora_calcetines.sv
`default_nettype none
// ============================================================================
// Module      : tb_empacadora_calcetines
// Description : Self-checking bench for the sock packer with a behavioural
//               model, directed scenarios and a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_empacadora_calcetines;

  localparam int PPB = 2;
  localparam int SC  = 3;
  localparam int CW  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          sock_valid = 1'b0;
  logic [2:0]    sock_code = 3'd0;
  logic          ready, held, pair_out, reject, box_done;
  logic [2:0]    held_code, box_code;
  logic [CW-1:0] total_boxes;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  empacadora_calcetines #(
    .PAIRS_PER_BOX (PPB),
    .SEAL_CYCLES   (SC),
    .CNT_W         (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sock_valid  (sock_valid),
    .sock_code   (sock_code),
    .ready       (ready),
    .held        (held),
    .held_code   (held_code),
    .pair_out    (pair_out),
    .reject      (reject),
    .box_done    (box_done),
    .box_code    (box_code),
    .total_boxes (total_boxes)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------------
  // Behavioural model: sock-level bookkeeping, updated once per clock edge.
  // ------------------------------------------------------------------------
  bit   m_held;
  int   m_hcode;
  int   m_pairs [8];
  int   m_seal_left;
  int   m_seal_code;
  int   m_total;
  bit   m_blocked;
  bit   m_acc;
  bit   e_pair, e_reject, e_box;
  int   e_bcode;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_held = 0; m_hcode = 0; m_seal_left = 0; m_seal_code = 0; m_total = 0;
      for (int k = 0; k < 8; k++) m_pairs[k] = 0;
      m_blocked = 0; e_pair = 0; e_reject = 0; e_box = 0; e_bcode = 0;
    end else begin
      m_acc     = sock_valid && (m_seal_left == 0);
      m_blocked = sock_valid && !m_acc;
      e_pair = 0; e_reject = 0; e_box = 0; e_bcode = 0;
      if (m_seal_left > 0) begin
        m_seal_left--;
        if (m_seal_left == 0) begin
          e_box = 1; e_bcode = m_seal_code; m_total++;
        end
      end
      if (m_acc) begin
        if (sock_code == 0) begin
          e_reject = 1;
        end else if (!m_held) begin
          m_held = 1; m_hcode = int'(sock_code);
        end else if (int'(sock_code) == m_hcode) begin
          e_pair = 1; m_held = 0; m_hcode = 0;
          m_pairs[sock_code]++;
          if (m_pairs[sock_code] == PPB) begin
            m_pairs[sock_code] = 0;
            m_seal_left = SC;
            m_seal_code = int'(sock_code);
          end
        end else begin
          e_reject = 1;
        end
      end
    end
  end

  // Compare process: every output, every cycle, away from the active edge.
  always @(negedge clk) begin
    if (!reset && cmp_en) begin
      chk("ready",       ready,       (m_seal_left == 0));
      chk("held",        held,        m_held);
      chk("held_code",   held_code,   m_hcode);
      chk("pair_out",    pair_out,    e_pair);
      chk("reject",      reject,      e_reject);
      chk("box_done",    box_done,    e_box);
      chk("box_code",    box_code,    e_bcode);
      chk("total_boxes", total_boxes, m_total % (1 << CW));
    end
  end

  // ------------------------------------------------------------------------
  // Stimulus helpers
  // ------------------------------------------------------------------------
  task automatic offer(input logic v, input logic [2:0] c);
    sock_valid = v;
    sock_code  = c;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    sock_valid = 1'b0;
    sock_code  = 3'd0;
    reset      = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", ready, 1);
    chk("rst_held", held, 0);
    chk("rst_total", total_boxes, 0);
  endtask

  // Waits (bounded) for ready; returns the number of not-ready cycles seen.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!ready) chk("wait_ready_timeout", 0, 1);
  endtask

  task automatic four(input logic [2:0] c);
    for (int k = 0; k < 4; k++) offer(1'b1, c);
  endtask

  int n;

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    #12;
    reset = 1'b0;
    @(negedge clk);
    cmp_en = 1'b1;
    chk("reset_ready", ready, 1);
    chk("reset_box_code", box_code, 0);

    // Pairing
    do_reset();
    offer(1'b1, 3'd3);
    chk("pair_held", held, 1);
    chk("pair_held_code", held_code, 3);
    offer(1'b1, 3'd3);
    chk("pair_pulse", pair_out, 1);
    chk("pair_held_clr", held, 0);
    offer(1'b0, 3'd0);
    chk("pair_no_box", box_done, 0);

    // Mismatch and invalid
    do_reset();
    offer(1'b1, 3'd2);
    chk("mm_held_code0", held_code, 2);
    offer(1'b1, 3'd5);
    chk("mm_reject5", reject, 1);
    chk("mm_held_code1", held_code, 2);
    offer(1'b1, 3'd0);
    chk("mm_reject0", reject, 1);
    chk("mm_held_code2", held_code, 2);
    offer(1'b1, 3'd2);
    chk("mm_pair", pair_out, 1);
    chk("mm_noreject", reject, 0);

    // Box seal
    do_reset();
    four(3'd6);
    sock_valid = 1'b0;
    chk("seal_pair", pair_out, 1);
    wait_ready(n);
    chk("seal_ready_low_cycles", n, 3);
    chk("seal_box_done", box_done, 1);
    chk("seal_box_code", box_code, 6);
    chk("seal_total", total_boxes, 1);

    // Backpressure
    do_reset();
    four(3'd4);
    sock_valid = 1'b1;
    sock_code  = 3'd1;
    n = 0;
    while (!ready && n < 50) begin
      chk("bp_no_accept", held, 0);
      n++;
      @(negedge clk);
    end
    chk("bp_wait", n, 3);
    @(negedge clk);
    sock_valid = 1'b0;
    chk("bp_accepted", held, 1);
    chk("bp_accepted_code", held_code, 1);
    offer(1'b0, 3'd0);
    offer(1'b0, 3'd0);
    chk("bp_no_dup", held, 1);
    offer(1'b1, 3'd1);
    chk("bp_pair", pair_out, 1);

    // Interleaved counters
    do_reset();
    offer(1'b1, 3'd1); offer(1'b1, 3'd1);
    offer(1'b1, 3'd2); offer(1'b1, 3'd2);
    chk("il_no_seal2", ready, 1);
    offer(1'b1, 3'd1); offer(1'b1, 3'd1);
    sock_valid = 1'b0;
    chk("il_seal1", ready, 0);
    wait_ready(n);
    chk("il_box1", box_code, 1);
    offer(1'b1, 3'd2); offer(1'b1, 3'd2);
    sock_valid = 1'b0;
    chk("il_seal2", ready, 0);
    wait_ready(n);
    chk("il_box2", box_code, 2);
    chk("il_total", total_boxes, 2);

    // Reset mid-seal, then verify counters were lost
    do_reset();
    offer(1'b1, 3'd3); offer(1'b1, 3'd3);
    four(3'd5);
    sock_valid = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rms_ready", ready, 1);
    chk("rms_held", held, 0);
    chk("rms_box_done", box_done, 0);
    chk("rms_total", total_boxes, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      offer(1'b0, 3'd0);
      chk("rms_no_box", box_done, 0);
    end
    offer(1'b1, 3'd3); offer(1'b1, 3'd3);
    sock_valid = 1'b0;
    chk("rms_cnt_lost", ready, 1);

    // Counter wrap: five boxes with a 2-bit counter
    do_reset();
    for (int b = 0; b < 5; b++) begin
      four(3'd7);
      sock_valid = 1'b0;
      wait_ready(n);
    end
    chk("wrap_total", total_boxes, 1);

    // Randomized phase; producer holds a sock that was not accepted.
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(0, 499) == 0) begin
        reset      = 1'b1;
        sock_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
      end
      if (!m_blocked) begin
        sock_valid = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 9) < 2) sock_code = 3'd0;
        else if ($urandom_range(0, 9) < 8) sock_code = 3'($urandom_range(1, 3));
        else sock_code = 3'($urandom_range(1, 7));
      end
      @(negedge clk);
    end
    sock_valid = 1'b0;
    @(negedge clk);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/empacadora_calcetines.md
# empacadora_calcetines

Downstream stage of the knitting machine in the sock factory. It takes finished socks, one code per accepted transfer, and pairs two consecutive socks of the same code. Matched pairs are counted into a per-code box. When a box holds `PAIRS_PER_BOX` pairs it is sealed over a fixed number of cycles, during which the block backpressures the knitter.

## Interface

Parameters:
- `PAIRS_PER_BOX`, default 6: pairs per sealed box, range 1..255.
- `SEAL_CYCLES`, default 4: cycles the sealer is busy, range 1..255.
- `CNT_W`, default 8: width of `total_boxes`.

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `sock_valid`  in  1: a sock is offered this cycle.
- `sock_code`  in  3: sock type. 1..7 are valid; 0 is invalid.
- `ready`  out  1: the block can accept a sock this cycle.
- `held`  out  1: one unpaired sock is held.
- `held_code`  out  3: code of the held sock; 0 when `held`=0.
- `pair_out`  out  1: one-cycle pulse, a pair was formed.
- `reject`  out  1: one-cycle pulse, the offered sock was discarded.
- `box_done`  out  1: one-cycle pulse, a box finished sealing.
- `box_code`  out  3: code of the sealed box; valid with `box_done`, 0 otherwise.
- `total_boxes`  out  `CNT_W`: boxes sealed since reset; wraps modulo 2^`CNT_W`.

## Operation

- Transfer accepted on an edge where `sock_valid`=1 and `ready`=1. If `ready`=0, the offered sock is not consumed; the producer holds it.
- States:
  - EMPTY: nothing held.
  - HALF: one sock held.
  - SEAL: box sealing in progress.
- EMPTY, accept with code≠0 → hold the code, go to HALF.
- Any state accepting code 0 → `reject` pulse; state unchanged.
- HALF, accept with code equal to held → pair formed:
  - `pair_out` pulse; held cleared.
  - `pairs[code]` incremented.
  - If the new count equals `PAIRS_PER_BOX`: clear `pairs[code]`, latch the code as the seal code, go to SEAL.
  - Otherwise go to EMPTY.
- HALF, accept with a different nonzero code → `reject` pulse. The held sock is kept; stay in HALF.
- SEAL: `ready`=0; the seal timer counts `SEAL_CYCLES` cycles. On the last cycle:
  - go to EMPTY;
  - `box_done`=1 and `box_code`=seal code for the following cycle;
  - `total_boxes`+1.
- Pair counters: seven counters, `pairs[1..7]`, each 8 bits.
- Reset value of every output and register is 0, except `ready`=1 after reset.
- Reset mid-SEAL abandons the box: no `box_done`, and counters and held sock are lost.

## Timing

- `ready` is combinational from state: 1 in EMPTY and HALF, 0 in SEAL.
- All other outputs are registered.
- `held`, `held_code`, `pair_out` and `reject` reflect an acceptance at edge N during cycle N+1.
- Seal-triggering pair accepted at edge N:
  - `pair_out` is high and `ready` is low in cycle N+1.
  - `ready` stays low for exactly `SEAL_CYCLES` cycles (N+1..N+SEAL_CYCLES).
  - `box_done` is high in cycle N+SEAL_CYCLES+1, and `ready` is already 1 in that cycle.
- Back-to-back transfers are allowed every cycle outside SEAL. Sustained throughput is one sock per cycle.
- `pair_out`, `reject` and `box_done` are mutually exclusive per cycle by construction.
- `total_boxes` updates in the same cycle `box_done` rises.

## Structure

- Shared package `calcetin_pkg`:
  - sock code constants: `CODE_NONE`=3'd0, plus names for codes 1..7;
  - state encoding EMPTY/HALF/SEAL (2 bits);
  - `SOCK_CODE_W`=3.
- Sub-module `seal_timer`:
  - down-counter loaded with `SEAL_CYCLES`-1 on start;
  - asserts `last` on the final count;
  - same `clk` and `reset` (asynchronous, active-high).
- Top level holds the FSM, held register, pair counter bank and output registers.

## Test plan

Benches use `PAIRS_PER_BOX`=2 and `SEAL_CYCLES`=3 unless noted.

- Pairing: reset, then codes 3, 3 on consecutive cycles → `held`=1 with `held_code`=3 after the first; `pair_out` pulse after the second; `held`=0; no `box_done`.
- Mismatch and invalid: codes 2, 5, 0, 2 → `reject` pulses for the 5 and the 0; `held_code` stays 2 throughout; `pair_out` after the final 2.
- Box seal: 4 socks of code 6 → `pair_out` twice; `ready`=0 for exactly 3 cycles; `box_done`=1 with `box_code`=6 one cycle later; `total_boxes`=1.
- Backpressure: hold `sock_valid`=1 with code 1 throughout a seal → no acceptance while `ready`=0; the sock is accepted on the first `ready`=1 cycle; nothing lost or duplicated.
- Interleaved counters: pairs 1, 2, 1 → only code 1 seals; `pairs[2]` remains 1. A following pair of 2 then seals with `box_code`=2.
- Reset mid-SEAL: assert `reset` in the 2nd seal cycle → outputs 0 and `ready`=1 immediately; no `box_done`; `total_boxes`=0. Separately, with `CNT_W`=2, 5 boxes → `total_boxes` wraps to 1.
